// File: rtl/dl.sv
// dl: DDR batch loader. Issues sequential batch reads and stores the returned 16-bit beats
// into a ring of batch buffers. Define DL_AUTO_RESTART_EN to re-arm a new frame after DONE.
module dl #(
  parameter int unsigned                 NUM                    = 2,
  parameter int unsigned                 WIDTH_ddr_addr         = 25,
  parameter int unsigned                 DS_data_NUM_in_1_batch = 224,
  parameter int unsigned                 SIZE_buffers           = 7,
  parameter int unsigned                 rdDS_Vaddr_DELTA       = 4032,
  parameter int unsigned                 WIDTH_BASE_ADDR        = 32,
  parameter logic [WIDTH_BASE_ADDR-1:0]  BASE_ADDR              = '0,
  parameter int unsigned                 MAX_WIDTH_Vaddr        = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               ddr_data,
  input  logic                      ddr_en,
  output logic                      ddr_req,
  output logic [WIDTH_ddr_addr-1:0] ddr_addr,
  output logic [WIDTH_ddr_addr-1:0] ddr_len
);

  localparam int unsigned NumBatches = NUM * SIZE_buffers;
  localparam int unsigned BeatW  = (DS_data_NUM_in_1_batch > 1) ? $clog2(DS_data_NUM_in_1_batch) : 1;
  localparam int unsigned SelW   = (SIZE_buffers > 1) ? $clog2(SIZE_buffers) : 1;
  localparam int unsigned BatchW = $clog2(NumBatches + 1);

  localparam logic [BeatW-1:0]           LastBeat     = BeatW'(DS_data_NUM_in_1_batch - 1);
  localparam logic [SelW-1:0]            LastSel      = SelW'(SIZE_buffers - 1);
  localparam logic [BatchW-1:0]          TotalBatches = BatchW'(NumBatches);
  localparam logic [MAX_WIDTH_Vaddr-1:0] VaddrDelta   = MAX_WIDTH_Vaddr'(rdDS_Vaddr_DELTA);
  localparam logic [WIDTH_ddr_addr-1:0]  BaseAddr     = BASE_ADDR[WIDTH_ddr_addr-1:0];
  localparam logic [WIDTH_ddr_addr-1:0]  BatchLen     = WIDTH_ddr_addr'(DS_data_NUM_in_1_batch / 4);

  typedef enum logic [2:0] {StIdle, StReq, StRecv, StNext, StDone} state_e;

  state_e                      state_q, state_d;
  logic [MAX_WIDTH_Vaddr-1:0]  vaddr_q, vaddr_d;
  logic [SelW-1:0]             buf_sel_q, buf_sel_d;
  logic [BatchW-1:0]           batch_cnt_q, batch_cnt_d;
  logic [BeatW-1:0]            beat_cnt_q, beat_cnt_d;
  logic                        req_q, req_d;
  logic [WIDTH_ddr_addr-1:0]   addr_q, addr_d;
  logic [WIDTH_ddr_addr-1:0]   len_q, len_d;
  logic                        buf_we;

  logic [15:0] buf_mem_q [SIZE_buffers][DS_data_NUM_in_1_batch];

  always_comb begin
    state_d     = state_q;
    vaddr_d     = vaddr_q;
    buf_sel_d   = buf_sel_q;
    batch_cnt_d = batch_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    buf_we      = 1'b0;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        // The beat that ends the request phase is already data and is captured.
        if (ddr_en) begin
          buf_we     = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          state_d    = StRecv;
        end
      end
      StRecv: begin
        if (ddr_en) begin
          buf_we = 1'b1;
          if (beat_cnt_q == LastBeat) begin
            beat_cnt_d = '0;
            state_d    = StNext;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      StNext: begin
        vaddr_d     = vaddr_q + VaddrDelta;
        buf_sel_d   = (buf_sel_q == LastSel) ? '0 : buf_sel_q + 1'b1;
        batch_cnt_d = batch_cnt_q + 1'b1;
        state_d     = (batch_cnt_d < TotalBatches) ? StReq : StDone;
      end
      StDone: begin
`ifdef DL_AUTO_RESTART_EN
        vaddr_d     = '0;
        buf_sel_d   = '0;
        batch_cnt_d = '0;
        state_d     = StReq;
`else
        state_d     = StDone;
`endif
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered off the next state so they line up with the REQ cycle.
    req_d  = (state_d == StReq);
    addr_d = addr_q;
    len_d  = len_q;
    if (state_d == StReq) begin
      addr_d = BaseAddr + WIDTH_ddr_addr'(vaddr_d);
      len_d  = BatchLen;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      vaddr_q     <= '0;
      buf_sel_q   <= '0;
      batch_cnt_q <= '0;
      beat_cnt_q  <= '0;
      req_q       <= 1'b0;
      addr_q      <= BaseAddr;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      vaddr_q     <= vaddr_d;
      buf_sel_q   <= buf_sel_d;
      batch_cnt_q <= batch_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
    end
  end

  // Reset takes priority over a beat arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (buf_we && !reset) begin
      buf_mem_q[buf_sel_q][beat_cnt_q] <= ddr_data;
    end
  end

  assign ddr_req  = req_q;
  assign ddr_addr = addr_q;
  assign ddr_len  = len_q;

endmodule

// File: tb/tb_dl.sv
// tb_dl: directed self-checking bench for the dl batch loader.
module tb_dl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ddr_data;
  logic        ddr_en;
  logic        ddr_req;
  logic [24:0] ddr_addr;
  logic [24:0] ddr_len;

  int   n_checks  = 0;
  int   n_errors  = 0;
  int   req_rises = 0;
  logic req_prev  = 1'b0;

  dl dut (
    .clk      (clk),
    .reset    (reset),
    .ddr_data (ddr_data),
    .ddr_en   (ddr_en),
    .ddr_req  (ddr_req),
    .ddr_addr (ddr_addr),
    .ddr_len  (ddr_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    req_prev <= ddr_req;
    if (ddr_req === 1'b1 && req_prev !== 1'b1) req_rises <= req_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int wcnt);
    wcnt = 0;
    while (ddr_req !== 1'b1 && wcnt < 50) begin
      tick();
      wcnt++;
    end
    check("req_seen", {31'd0, (ddr_req === 1'b1)}, 32'd1);
  endtask

  // Beat k carries {tag, k}; a 3-cycle ddr_en gap precedes beat gap_at.
  task automatic send_beats(input logic [7:0] tag, input int from, input int to, input int gap_at);
    for (int k = from; k < to; k++) begin
      if (k == gap_at) begin
        ddr_en = 1'b0;
        repeat (3) tick();
      end
      ddr_en   = 1'b1;
      ddr_data = {tag, 8'(k)};
      tick();
      if (k == 0) check("req_fall", {31'd0, ddr_req}, 32'd0);
    end
    ddr_en = 1'b0;
  endtask

  task automatic serve(input logic [7:0] tag, input int gap_at, output logic [24:0] addr,
                       output int wcnt);
    wait_req(wcnt);
    addr = ddr_addr;
    check("len", ddr_len, 32'd56);
    repeat (5) tick();
    send_beats(tag, 0, 224, gap_at);
    check("req_after_last", {31'd0, ddr_req}, 32'd0);
  endtask

  initial begin
    logic [24:0] addr_log [14];
    int          wc [14];
    logic [24:0] a;
    int          w;
    int          hi;

    reset    = 1'b1;
    ddr_en   = 1'b0;
    ddr_data = '0;
    repeat (2) tick();
    check("rst_req", {31'd0, ddr_req}, 32'd0);
    check("rst_addr", ddr_addr, 32'd0);
    check("rst_len", ddr_len, 32'd0);
    reset = 1'b0;
    check("rel_req_still_lo", {31'd0, ddr_req}, 32'd0);
    tick();
    check("req_rise", {31'd0, ddr_req}, 32'd1);
    check("addr0", ddr_addr, 32'd0);
    check("len0", ddr_len, 32'd56);

    for (int b = 0; b < 14; b++) begin
      serve(8'(b), (b == 1) ? 100 : -1, addr_log[b], wc[b]);
      if (b == 7) begin
        check("buf0_overwritten", {16'd0, dut.buf_mem_q[0][5]}, 32'h0705);
        check("buf6_beat0", {16'd0, dut.buf_mem_q[6][0]}, 32'h0600);
        check("buf6_beat1", {16'd0, dut.buf_mem_q[6][1]}, 32'h0601);
        check("buf6_last", {16'd0, dut.buf_mem_q[6][223]}, 32'h06df);
        check("buf1_gap99", {16'd0, dut.buf_mem_q[1][99]}, 32'h0163);
        check("buf1_gap100", {16'd0, dut.buf_mem_q[1][100]}, 32'h0164);
        check("buf1_gap101", {16'd0, dut.buf_mem_q[1][101]}, 32'h0165);
        check("buf1_last", {16'd0, dut.buf_mem_q[1][223]}, 32'h01df);
      end
    end
    check("wait_b1", wc[1], 32'd1);
    check("wait_after_gap", wc[2], 32'd1);
    check("addr_b0", addr_log[0], 32'd0);
    check("addr_b1", addr_log[1], 32'd4032);
    check("addr_b7", addr_log[7], 32'd28224);
    check("addr_b13", addr_log[13], 32'd52416);

`ifdef DL_AUTO_RESTART_EN
    wait_req(w);
    check("restart_addr", ddr_addr, 32'd0);
    @(negedge clk);
    #1;
    check("req_count", req_rises, 32'd15);
`else
    hi = 0;
    repeat (1000) begin
      tick();
      if (ddr_req !== 1'b0) hi++;
    end
    check("done_quiet", hi, 32'd0);
    @(negedge clk);
    #1;
    check("req_count", req_rises, 32'd14);
`endif

    // Second frame: abort with reset at beat 100 of batch 2.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    serve(8'h20, -1, a, w);
    check("f2_addr0", a, 32'd0);
    serve(8'h21, -1, a, w);
    check("f2_addr1", a, 32'd4032);
    wait_req(w);
    check("f2_addr2", ddr_addr, 32'd8064);
    repeat (5) tick();
    send_beats(8'h22, 0, 100, -1);
    reset    = 1'b1;
    ddr_en   = 1'b1;
    ddr_data = 16'h2264;
    tick();
    check("mid_rst_req", {31'd0, ddr_req}, 32'd0);
    check("mid_rst_addr", ddr_addr, 32'd0);
    check("mid_rst_len", ddr_len, 32'd0);
    ddr_data = 16'h2265;
    tick();
    reset    = 1'b0;
    ddr_data = 16'hbeef;
    tick();
    ddr_en = 1'b0;
    check("rearm_req", {31'd0, ddr_req}, 32'd1);
    check("rearm_addr", ddr_addr, 32'd0);
    check("buf2_partial99", {16'd0, dut.buf_mem_q[2][99]}, 32'h2263);
    check("buf2_rst_beat", {16'd0, dut.buf_mem_q[2][100]}, 32'h0964);
    check("buf0_spurious", {16'd0, dut.buf_mem_q[0][0]}, 32'h2000);

    serve(8'h30, -1, a, w);
    check("rec_addr", a, 32'd0);
    check("rec_wait", w, 32'd0);
    check("rec_buf0_b0", {16'd0, dut.buf_mem_q[0][0]}, 32'h3000);
    check("rec_buf0_b1", {16'd0, dut.buf_mem_q[0][1]}, 32'h3001);
    wait_req(w);
    check("rec_next_addr", ddr_addr, 32'd4032);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
